disco_mem_arbiter: RTL and testbench
====================================

DISCO_MEM_ARBITER -- requirements
Module: disco_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width of both requester ports.
REQ-002 SHALL have parameter MAX_WAIT, default 4, maximum consecutive cycles a pending fetch may be refused.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports if_req in 1, if_addr in ADDR_W, if_gnt out 1, if_rvalid out 1, if_rdata out 16: instruction-fetch requester.
REQ-006 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in 16, d_gnt out 1, d_rvalid out 1, d_rdata out 16: load/store requester.
REQ-007 SHALL have port halt  in  1  when high, no new fetch grants are issued.
REQ-008 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W-1, mem_wdata out 16, mem_rdata in 16: single-port synchronous 16-bit memory; read data valid one cycle after mem_en.

Function
REQ-009 SHALL hold a request: requester keeps req, addr, we and wdata stable until the cycle its gnt is high; request is consumed in that cycle.
REQ-010 SHALL generate if_gnt and d_gnt combinationally from requests, halt and registered arbitration state; at most one gnt high per cycle.
REQ-011 SHALL drive mem_en = if_gnt | d_gnt, with mem_addr = granted addr[ADDR_W-1:1], mem_we = d_gnt & d_we, mem_wdata = d_wdata; bit 0 of both addresses is ignored.
REQ-012 SHALL register the owner of each granted access and, exactly one cycle after the grant, pulse that port's rvalid for one cycle.
REQ-013 SHALL present mem_rdata on if_rdata/d_rdata in the rvalid cycle; on a data write d_rvalid still pulses (write acknowledge) and d_rdata is don't-care.
REQ-014 SHALL sustain one grant per cycle; back-to-back grants to the same or alternating ports are legal, with responses in grant order.
REQ-015 SHALL use fixed priority data over fetch by default: if both requesters are pending, d_gnt wins.
REQ-016 SHALL keep a wait counter (width clog2(MAX_WAIT+1)): increments each cycle if_req=1, halt=0 and if_gnt=0; saturates at MAX_WAIT; clears on if_gnt or if_req=0.
REQ-017 SHALL, when the wait counter equals MAX_WAIT, grant fetch over a pending data request in that cycle (starvation override).
REQ-018 SHALL, with halt=1, grant no fetch and hold the wait counter; data requests are still served; a fetch response already in flight still completes.
REQ-019 SHALL, with no request granted, drive mem_en=0, mem_we=0; mem_addr and mem_wdata are don't-care.

Reset
REQ-020 SHALL, while reset=0, asynchronously force if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en and mem_we to 0, the wait counter to 0, and the owner/last-grant state to "fetch".
REQ-021 SHALL drop any in-flight response when reset is asserted mid-access; no rvalid pulse follows reset release.
REQ-022 SHALL drive if_rdata and d_rdata to 0 during reset.
REQ-023 SHALL evaluate the first grant on the first rising edge after reset release.

Configuration
REQ-024 SHALL, with macro DISCO_ARB_RR_EN defined, replace fixed priority with round-robin: on contention the port not granted last wins; the wait counter and REQ-017 are removed.
REQ-025 SHALL, without DISCO_ARB_RR_EN, implement REQ-015 to REQ-017 exactly; port list is identical in both builds.

Verification
REQ-026 SHALL cover single fetch: if_req=1, if_addr=0x0010 -> same cycle if_gnt=1, mem_addr=0x008; next cycle if_rvalid=1, if_rdata equals the memory word at index 0x008.
REQ-027 SHALL cover contention: if_req=1 and d_req=1 (read 0x0020) in the same cycle -> d_gnt first; if_gnt the next cycle; d_rvalid and if_rvalid on consecutive cycles.
REQ-028 SHALL cover starvation, MAX_WAIT=4: d_req held high for 10 cycles with if_req high -> if_gnt in the 5th cycle, then d_gnt resumes.
REQ-029 SHALL cover a write: d_we=1, d_addr=0x0040, d_wdata=0xBEEF -> mem_we=1 for one cycle; next cycle d_rvalid=1; a subsequent read of 0x0040 returns 0xBEEF.
REQ-030 SHALL cover halt: halt=1 with if_req=1 for 8 cycles -> no if_gnt, wait counter frozen; a d_req read is served normally.
REQ-031 SHALL cover reset mid-access: reset=0 in the cycle after a grant -> no rvalid; all outputs 0 until release.

Source files
------------

// File: rtl/disco_mem_arbiter.sv
// disco_mem_arbiter: fetch/load-store arbiter in front of one single-port synchronous 16-bit memory.
// Build option DISCO_ARB_RR_EN: round-robin on contention instead of data-first with fetch starvation override.
module disco_mem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [15:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [15:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [15:0]       d_rdata,
  input  logic              halt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata
);

  logic if_win;
  logic unused_addr_lsb;

  // Memory is word-addressed; byte-address bit 0 carries no information.
  assign unused_addr_lsb = ^{if_addr[0], d_addr[0]};

`ifdef DISCO_ARB_RR_EN
  logic last_if;

  // Remember which port won last so contention alternates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_if <= 1'b1;
    end else if (if_gnt || d_gnt) begin
      last_if <= if_gnt;
    end
  end

  assign if_win = !d_req || !last_if;
`else
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  // Count consecutive refused fetch cycles; frozen while halted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      wait_cnt <= '0;
    end else if (!halt && (wait_cnt != WAIT_MAX)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign if_win = !d_req || (wait_cnt == WAIT_MAX);
`endif

  // Grants are combinational so a request is consumed in the cycle it is presented.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (reset) begin
      if_gnt = if_req && !halt && if_win;
      d_gnt  = d_req && !if_gnt;
    end
  end

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = if_gnt ? if_addr[ADDR_W-1:1] : d_addr[ADDR_W-1:1];
    mem_wdata = d_wdata;
  end

  // Response owner tracking: memory data returns one cycle after the grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      d_rvalid  <= d_gnt;
    end
  end

  assign if_rdata = if_rvalid ? mem_rdata : 16'h0000;
  assign d_rdata  = d_rvalid  ? mem_rdata : 16'h0000;

endmodule

// File: tb/tb_disco_mem_arbiter.sv
// Directed self-checking bench for disco_mem_arbiter (default fixed-priority build, MAX_WAIT=4).
module tb_disco_mem_arbiter;

  localparam int unsigned ADDR_W = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [15:0]       if_rdata;
  logic              d_req = 1'b0, d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [15:0]       d_wdata = '0;
  logic              d_gnt, d_rvalid;
  logic [15:0]       d_rdata;
  logic              halt = 1'b0;
  logic              mem_en, mem_we;
  logic [ADDR_W-2:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata = '0;

  logic [15:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  disco_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .halt(halt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous single-port memory model, word i initialised to 0x5000 | i.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic test_reset();
    if_req = 1'b1; d_req = 1'b1;
    #2;
    checks++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we});
    end
    checks++;
    if ({if_rdata, d_rdata} !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 00000000", {if_rdata, d_rdata});
    end
    @(negedge clock); if_req = 1'b0; d_req = 1'b0;
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_single_fetch();
    @(negedge clock); if_req = 1'b1; if_addr = 16'h0010;
    #1;
    checks++;
    if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b1010) begin
      errors++; $display("FAIL fetch_gnt: got %b expected 1010", {if_gnt, d_gnt, mem_en, mem_we});
    end
    checks++;
    if (mem_addr !== 15'h0008) begin
      errors++; $display("FAIL fetch_addr: got %h expected 0008", mem_addr);
    end
    @(negedge clock); if_req = 1'b0;
    #1;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 16'h5008}) begin
      errors++; $display("FAIL fetch_resp: got %b/%h expected 1/5008", if_rvalid, if_rdata);
    end
    @(negedge clock); #1;
    checks++;
    if (if_rvalid !== 1'b0) begin
      errors++; $display("FAIL fetch_pulse: got %b expected 0", if_rvalid);
    end
  endtask

  task automatic test_contention();
    @(negedge clock);
    if_req = 1'b1; if_addr = 16'h0030; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    #1;
    checks++;
    if ({d_gnt, if_gnt, mem_addr} !== {2'b10, 15'h0010}) begin
      errors++; $display("FAIL cont_first: got d=%b i=%b a=%h expected d=1 i=0 a=0010", d_gnt, if_gnt, mem_addr);
    end
    @(negedge clock); d_req = 1'b0;
    #1;
    checks++;
    if ({if_gnt, mem_addr} !== {1'b1, 15'h0018}) begin
      errors++; $display("FAIL cont_second: got i=%b a=%h expected i=1 a=0018", if_gnt, mem_addr);
    end
    checks++;
    if ({d_rvalid, d_rdata} !== {1'b1, 16'h5010}) begin
      errors++; $display("FAIL cont_d_resp: got %b/%h expected 1/5010", d_rvalid, d_rdata);
    end
    @(negedge clock); if_req = 1'b0;
    #1;
    checks++;
    if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, 16'h5018}) begin
      errors++; $display("FAIL cont_if_resp: got %b%b/%h expected 10/5018", if_rvalid, d_rvalid, if_rdata);
    end
  endtask

  task automatic test_starvation();
    logic exp_if;
    @(negedge clock);
    if_req = 1'b1; if_addr = 16'h0002; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0000;
    for (int c = 1; c <= 10; c++) begin
      #1;
      exp_if = (c == 5);
      checks++;
      if ({if_gnt, d_gnt} !== {exp_if, !exp_if}) begin
        errors++; $display("FAIL starve_c%0d: got i=%b d=%b expected i=%b d=%b", c, if_gnt, d_gnt, exp_if, !exp_if);
      end
      @(negedge clock);
      if (c == 5) if_req = 1'b0;
    end
    d_req = 1'b0;
  endtask

  task automatic test_write();
    @(negedge clock); d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    #1;
    checks++;
    if ({d_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 15'h0020, 16'hBEEF}) begin
      errors++; $display("FAIL wr_issue: got %b%b%b a=%h w=%h expected 111 a=0020 w=beef", d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clock); d_req = 1'b0; d_we = 1'b0;
    #1;
    checks++;
    if ({d_rvalid, mem_we, mem_en} !== 3'b100) begin
      errors++; $display("FAIL wr_ack: got %b expected 100", {d_rvalid, mem_we, mem_en});
    end
    @(negedge clock); d_req = 1'b1; d_addr = 16'h0040;
    #1;
    checks++;
    if ({d_gnt, mem_we} !== 2'b10) begin
      errors++; $display("FAIL wr_readback_gnt: got %b expected 10", {d_gnt, mem_we});
    end
    @(negedge clock); d_req = 1'b0;
    #1;
    checks++;
    if ({d_rvalid, d_rdata} !== {1'b1, 16'hBEEF}) begin
      errors++; $display("FAIL wr_readback: got %b/%h expected 1/beef", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_halt();
    logic exp_if;
    // Preload the wait counter to 2, freeze it for 8 halted cycles, then fetch wins on the 3rd cycle.
    @(negedge clock);
    if_req = 1'b1; if_addr = 16'h0050; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0060;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({if_gnt, d_gnt} !== 2'b01) begin
        errors++; $display("FAIL halt_pre_c%0d: got %b expected 01", c, {if_gnt, d_gnt});
      end
      @(negedge clock);
    end
    halt = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if ({if_gnt, d_gnt} !== 2'b01) begin
        errors++; $display("FAIL halt_c%0d: got %b expected 01", c, {if_gnt, d_gnt});
      end
      @(negedge clock);
    end
    halt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      exp_if = (c == 2);
      checks++;
      if ({if_gnt, d_gnt} !== {exp_if, !exp_if}) begin
        errors++; $display("FAIL halt_release_c%0d: got %b expected %b%b", c, {if_gnt, d_gnt}, exp_if, !exp_if);
      end
      @(negedge clock);
      if (c == 2) begin if_req = 1'b0; d_req = 1'b0; end
    end
  endtask

  task automatic test_halt_inflight();
    @(negedge clock); if_req = 1'b1; if_addr = 16'h0010;
    #1;
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++; $display("FAIL inflight_gnt: got %b expected 1", if_gnt);
    end
    @(negedge clock); halt = 1'b1; if_addr = 16'h0012;
    #1;
    checks++;
    if ({if_gnt, mem_en, if_rvalid, if_rdata} !== {3'b001, 16'h5008}) begin
      errors++; $display("FAIL inflight_resp: got %b%b%b/%h expected 001/5008", if_gnt, mem_en, if_rvalid, if_rdata);
    end
    @(negedge clock); halt = 1'b0;
    #1;
    checks++;
    if ({if_gnt, mem_addr} !== {1'b1, 15'h0009}) begin
      errors++; $display("FAIL inflight_resume: got %b a=%h expected 1 a=0009", if_gnt, mem_addr);
    end
    @(negedge clock); if_req = 1'b0;
    #1;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 16'h5009}) begin
      errors++; $display("FAIL inflight_resume_resp: got %b/%h expected 1/5009", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock); if_req = 1'b1; if_addr = 16'h0010; d_req = 1'b1; d_addr = 16'h0040;
    #1;
    checks++;
    if ({if_gnt, d_gnt} !== 2'b01) begin
      errors++; $display("FAIL rstmid_gnt: got %b expected 01", {if_gnt, d_gnt});
    end
    #2; reset = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, if_rdata, d_rdata} !== 38'h0) begin
        errors++; $display("FAIL rstmid_hold_c%0d: got %b%b%b%b%b%b %h %h expected all zero",
                           c, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, if_rdata, d_rdata);
      end
      @(negedge clock); #1;
    end
    if_req = 1'b0; d_req = 1'b0; reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock); #1;
      checks++;
      if ({if_rvalid, d_rvalid} !== 2'b00) begin
        errors++; $display("FAIL rstmid_release_c%0d: got %b expected 00", c, {if_rvalid, d_rvalid});
      end
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
    #1;
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL rstmid_first_gnt: got %b expected 1", d_gnt);
    end
    @(negedge clock); d_req = 1'b0;
    #1;
    checks++;
    if ({d_rvalid, d_rdata} !== {1'b1, 16'hBEEF}) begin
      errors++; $display("FAIL rstmid_first_resp: got %b/%h expected 1/beef", d_rvalid, d_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h5000 | 16'(i);
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_write();
    test_halt();
    test_halt_inflight();
    test_reset_mid();
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
